multi_sphere_renderer: RTL and testbench

- N-ball successor of the single bouncing-sphere renderer. Each ball has its own position, direction and speed divider, and bounces inside a FIELD_W x FIELD_H field in compressed pixel coordinates.
- For every pixel coordinate presented, the block produces a 4-bit shaded intensity from all balls, combined by a selectable blend mode.
- Sits between the compressed VGA timing counters and the palette/colour stage.

---
 rtl/multi_sphere_renderer.sv | 147 ++++++++++++++
 tb/tb_multi_sphere_renderer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_sphere_renderer.sv
// rtl/multi_sphere_renderer.sv - N independently bouncing shaded balls rendered per pixel
// Two-stage pipeline: squared distances per ball, then per-ball shade combined by max or saturating sum.
module multi_sphere_renderer #(
  parameter int NUM_BALLS = 4,
  parameter int COORD_W   = 7,
  parameter int SPD_W     = 21,
  parameter int FIELD_W   = 80,
  parameter int FIELD_H   = 60,
  parameter int MARGIN    = 10,
  parameter int RADIUS_SQ = 32,
  parameter int EDGE_SOFT = 128
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [COORD_W-1:0]         compr_hrw,
  input  logic [COORD_W-1:0]         compr_vrw,
  input  logic [NUM_BALLS*SPD_W-1:0] top,
  input  logic [NUM_BALLS-1:0]       starth,
  input  logic [NUM_BALLS-1:0]       startv,
  input  logic                       restart,
  input  logic                       pause,
  input  logic                       blend_mode,
  output logic [3:0]                 colorv,
  output logic [NUM_BALLS-1:0]       bounce
);

  localparam int DW = 2 * (COORD_W + 1);
  localparam logic [COORD_W-1:0] LO    = COORD_W'(MARGIN);
  localparam logic [COORD_W-1:0] HI_H  = COORD_W'(FIELD_W - MARGIN);
  localparam logic [COORD_W-1:0] HI_V  = COORD_W'(FIELD_H - MARGIN);
  localparam logic [COORD_W-1:0] MID_V = COORD_W'(FIELD_H / 2);
  localparam logic [DW-1:0] RSQ    = DW'(RADIUS_SQ);
  localparam logic [DW-1:0] CORE_T = DW'(RADIUS_SQ + 16);
  localparam logic [DW-1:0] RING_T = DW'(RADIUS_SQ + EDGE_SOFT);

  logic [COORD_W-1:0] pos_h [NUM_BALLS];
  logic [COORD_W-1:0] pos_v [NUM_BALLS];
  logic [COORD_W-1:0] nxt_pos_h [NUM_BALLS];
  logic [COORD_W-1:0] nxt_pos_v [NUM_BALLS];
  logic [SPD_W-1:0]   cnt [NUM_BALLS];
  logic [NUM_BALLS-1:0] dir_h, dir_v, nxt_dir_h, nxt_dir_v, hit;
  logic [DW-1:0] dist_d [NUM_BALLS];
  logic [DW-1:0] dist_q [NUM_BALLS];
  logic [3:0]    color_d;

  function automatic logic [COORD_W-1:0] home_h(input int i);
    return COORD_W'(MARGIN + 2 + 8 * i);
  endfunction

  function automatic logic [3:0] shade(input logic [DW-1:0] d);
    logic [DW-1:0] q;
    if (d < CORE_T) return 4'd15;
    if (d >= RING_T) return 4'd0;
    q = (d - RSQ) >> 3;
    if (q <= DW'(1)) return 4'd15;
    if (q >= DW'(16)) return 4'd0;
    return 4'(DW'(16) - q);
  endfunction

  // Edge tests use the current position; the step then follows the new direction.
  always_comb begin
    hit       = '0;
    nxt_dir_h = '0;
    nxt_dir_v = '0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      hit[i]       = (cnt[i] == top[i*SPD_W +: SPD_W]);
      nxt_dir_h[i] = (pos_h[i] < LO) ? 1'b1 : (pos_h[i] > HI_H) ? 1'b0 : dir_h[i];
      nxt_dir_v[i] = (pos_v[i] < LO) ? 1'b1 : (pos_v[i] > HI_V) ? 1'b0 : dir_v[i];
      nxt_pos_h[i] = nxt_dir_h[i] ? pos_h[i] + 1'b1 : pos_h[i] - 1'b1;
      nxt_pos_v[i] = nxt_dir_v[i] ? pos_v[i] + 1'b1 : pos_v[i] - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        pos_h[i] <= home_h(i);
        pos_v[i] <= MID_V;
        dir_h[i] <= (i % 2 == 0);
        dir_v[i] <= ((i / 2) % 2 == 1);
        cnt[i]   <= '0;
      end
      bounce <= '0;
    end else if (restart) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        pos_h[i] <= home_h(i);
        pos_v[i] <= MID_V;
        cnt[i]   <= '0;
      end
      dir_h  <= starth;
      dir_v  <= startv;
      bounce <= '0;
    end else if (pause) begin
      bounce <= '0;
    end else begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        if (hit[i]) begin
          pos_h[i]  <= nxt_pos_h[i];
          pos_v[i]  <= nxt_pos_v[i];
          dir_h[i]  <= nxt_dir_h[i];
          dir_v[i]  <= nxt_dir_v[i];
          cnt[i]    <= '0;
          bounce[i] <= (nxt_dir_h[i] != dir_h[i]) || (nxt_dir_v[i] != dir_v[i]);
        end else begin
          cnt[i]    <= cnt[i] + 1'b1;
          bounce[i] <= 1'b0;
        end
      end
    end
  end

  // Differences are one bit wider than coordinates so wrap-free signed values square cleanly.
  always_comb begin
    logic signed [DW-1:0] dh, dv;
    for (int i = 0; i < NUM_BALLS; i++) begin
      dh = DW'($signed({1'b0, compr_hrw} - {1'b0, pos_h[i]}));
      dv = DW'($signed({1'b0, compr_vrw} - {1'b0, pos_v[i]}));
      dist_d[i] = dh * dh + dv * dv;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_BALLS; i++) dist_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BALLS; i++) dist_q[i] <= dist_d[i];
    end
  end

  always_comb begin
    logic [7:0] acc;
    logic [7:0] s;
    acc = '0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      s = {4'd0, shade(dist_q[i])};
      if (blend_mode) acc = acc + s;
      else if (s > acc) acc = s;
    end
    color_d = (acc > 8'd15) ? 4'd15 : acc[3:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) colorv <= '0;
    else        colorv <= color_d;
  end

endmodule

// File: tb/tb_multi_sphere_renderer.sv
// tb/tb_multi_sphere_renderer.sv - randomized and directed checks against a behavioural ball model
module tb_multi_sphere_renderer;

  localparam int NB = 4;
  localparam int SW = 21;
  localparam logic [SW-1:0] TOP_MAX = '1;

  logic clk, reset;
  logic [6:0] hrw, vrw;
  logic [NB*SW-1:0] top;
  logic [NB-1:0] starth, startv;
  logic restart, pause, blend_mode;
  logic [3:0] colorv;
  logic [NB-1:0] bounce;

  int total, bad;
  bit chk_on;

  multi_sphere_renderer #(
    .NUM_BALLS(NB), .COORD_W(7), .SPD_W(SW), .FIELD_W(80), .FIELD_H(60),
    .MARGIN(10), .RADIUS_SQ(32), .EDGE_SOFT(128)
  ) dut (
    .clk(clk), .reset(reset), .compr_hrw(hrw), .compr_vrw(vrw), .top(top),
    .starth(starth), .startv(startv), .restart(restart), .pause(pause),
    .blend_mode(blend_mode), .colorv(colorv), .bounce(bounce)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: balls as plain integers, pipeline as two registered values.
  int mph[NB], mpv[NB], mdh[NB], mdv[NB], md[NB];
  longint mcnt[NB];
  int mcol;
  logic [NB-1:0] mbnc;

  function automatic int shade_of(input int d);
    int v;
    if (d < 48) return 15;
    if (d >= 160) return 0;
    v = 16 - (d - 32) / 8;
    return (v > 15) ? 15 : v;
  endfunction

  task automatic model_home();
    for (int i = 0; i < NB; i++) begin
      mph[i] = 12 + 8 * i;
      mpv[i] = 30;
      mcnt[i] = 0;
    end
  endtask

  always @(posedge clk or negedge reset) begin : mdl
    int acc, s, nh, nv, dx, dy;
    if (!reset) begin
      model_home();
      for (int i = 0; i < NB; i++) begin
        mdh[i] = (i % 2 == 0);
        mdv[i] = ((i / 2) % 2);
        md[i] = 0;
      end
      mcol = 0;
      mbnc = '0;
    end else begin
      acc = 0;
      for (int i = 0; i < NB; i++) begin
        s = shade_of(md[i]);
        if (blend_mode) acc += s;
        else if (s > acc) acc = s;
      end
      mcol = (acc > 15) ? 15 : acc;
      for (int i = 0; i < NB; i++) begin
        dx = int'(hrw) - mph[i];
        dy = int'(vrw) - mpv[i];
        md[i] = dx * dx + dy * dy;
      end
      if (restart) begin
        model_home();
        for (int i = 0; i < NB; i++) begin
          mdh[i] = starth[i];
          mdv[i] = startv[i];
        end
        mbnc = '0;
      end else if (pause) begin
        mbnc = '0;
      end else begin
        for (int i = 0; i < NB; i++) begin
          if (mcnt[i] == longint'(top[i*SW +: SW])) begin
            nh = (mph[i] < 10) ? 1 : (mph[i] > 70) ? 0 : mdh[i];
            nv = (mpv[i] < 10) ? 1 : (mpv[i] > 50) ? 0 : mdv[i];
            mbnc[i] = (nh != mdh[i]) || (nv != mdv[i]);
            mdh[i] = nh;
            mdv[i] = nv;
            mph[i] = (mph[i] + (nh ? 1 : 127)) % 128;
            mpv[i] = (mpv[i] + (nv ? 1 : 127)) % 128;
            mcnt[i] = 0;
          end else begin
            mcnt[i] = (mcnt[i] + 1) % (longint'(1) << SW);
            mbnc[i] = 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("colorv", int'(colorv), mcol);
      check("bounce", int'(bounce), int'(mbnc));
    end
  end

  task automatic render(input int h, input int v, input int exp, input string name);
    @(negedge clk);
    hrw = 7'(h);
    vrw = 7'(v);
    @(negedge clk);
    @(negedge clk);
    check(name, int'(colorv), exp);
  endtask

  task automatic set_tops(input logic [SW-1:0] t0, input logic [SW-1:0] rest);
    for (int i = 0; i < NB; i++) top[i*SW +: SW] = (i == 0) ? t0 : rest;
  endtask

  initial begin : stim
    int n, at;
    reset = 0; hrw = 0; vrw = 0; top = '0; starth = '0; startv = '0;
    restart = 0; pause = 0; blend_mode = 0; chk_on = 0; total = 0; bad = 0;
    repeat (2) @(negedge clk);
    chk_on = 1;
    @(negedge clk);
    check("reset_colorv", int'(colorv), 0);
    check("reset_bounce", int'(bounce), 0);
    pause = 1;
    reset = 1;

    render(16, 30, 15, "core_hit");
    render(60, 5, 0, "far_miss");
    render(12, 37, 14, "ramp_d49");
    render(12, 41, 5, "ramp_d121");
    render(12, 43, 0, "ramp_d169");
    render(12, 23, 14, "ramp_neg_v");
    render(5, 30, 14, "ramp_neg_h");

    blend_mode = 1;
    render(12, 37, 15, "sum_saturate");
    render(12, 41, 5, "sum_single");

    // Move ball 0 one step to (11,31) so pixel (17,41) sees shades 3 and 4.
    @(negedge clk);
    restart = 1; pause = 0; starth = '0; startv = 4'b0001; set_tops('0, TOP_MAX);
    @(negedge clk);
    restart = 0;
    @(negedge clk);
    set_tops(TOP_MAX, TOP_MAX);
    render(17, 41, 7, "sum_disjoint");
    blend_mode = 0;
    render(17, 41, 4, "max_disjoint");

    @(negedge clk);
    restart = 1; starth = '0; startv = '0; set_tops(21'd3, TOP_MAX);
    @(negedge clk);
    restart = 0;
    n = 0; at = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bounce[0]) begin
        n++;
        at = k;
      end
    end
    check("bounce_count", n, 1);
    check("bounce_cycle", at, 16);

    @(negedge clk);
    restart = 1; pause = 1; set_tops('0, '0); starth = 4'b1010; startv = 4'b0110;
    @(negedge clk);
    restart = 0;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bounce != 0) n++;
    end
    check("pause_no_bounce", n, 0);
    render(12, 37, 14, "pause_hold");
    @(negedge clk);
    pause = 0;
    repeat (20) @(negedge clk);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      hrw = 7'($urandom_range(0, 90));
      vrw = 7'($urandom_range(0, 70));
      blend_mode = $urandom_range(0, 1);
      pause = ($urandom_range(0, 7) == 0);
      restart = ($urandom_range(0, 199) == 0);
      starth = 4'($urandom);
      startv = 4'($urandom);
      if (c % 100 == 0)
        for (int i = 0; i < NB; i++) top[i*SW +: SW] = SW'($urandom_range(0, 5));
    end

    @(negedge clk);
    restart = 1; pause = 1; blend_mode = 0;
    @(negedge clk);
    restart = 0;
    render(16, 30, 15, "pre_reset_hit");
    pause = 0; set_tops('0, '0);
    @(posedge clk);
    #3 reset = 0;
    #1 check("async_colorv", int'(colorv), 0);
    check("async_bounce", int'(bounce), 0);
    repeat (2) @(negedge clk);
    pause = 1;
    reset = 1;
    render(16, 30, 15, "post_reset_hit");
    render(12, 37, 14, "post_reset_ramp");
    render(36, 30, 15, "post_reset_ball3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
